poly1305_block_mul: RTL

POLY1305_BLOCK_MUL -- requirements
Module: poly1305_block_mul

---
 rtl/poly1305_block_mul.sv | 103 ++++++++++
 1 files changed

// File: rtl/poly1305_block_mul.sv
// Poly1305 block multiplier: (h + {hibit,m}) * clamp(r) by bit-serial shift-and-add.
// Fixed 130-edge latency from acceptance to out_valid; the result is held until out_ready.
module poly1305_block_mul (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [129:0] acc_in,
  input  logic [127:0] block_in,
  input  logic         hibit,
  input  logic [127:0] r_in,
  input  logic         out_ready,
  output logic [257:0] product,
  output logic         out_valid,
  output logic         busy
);

  localparam int DATA_W = 130;
  localparam int COEF_W = 128;
  localparam int PROD_W = 258;
  localparam logic [COEF_W-1:0] R_MASK = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

  function automatic logic [COEF_W-1:0] clamp_r(input logic [COEF_W-1:0] r);
    return r & R_MASK;
  endfunction

  typedef enum logic [1:0] {IDLE, ADD, MUL, OUT} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   acc_p0;
  logic [COEF_W:0]     blk_p0;
  logic [COEF_W-1:0]   r_p0;
  logic [DATA_W:0]     s_p1;
  logic [PROD_W-1:0]   acc_p2;
  logic [6:0]          cnt_p2;
  logic                last_p2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     state_nxt = MUL;
      MUL:     if (last_p2) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_p0    <= '0;
      blk_p0    <= '0;
      r_p0      <= '0;
      s_p1      <= '0;
      acc_p2    <= '0;
      cnt_p2    <= '0;
      last_p2   <= 1'b0;
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        // p0: operand capture
        IDLE: begin
          if (start) begin
            acc_p0 <= acc_in;
            blk_p0 <= {hibit, block_in};
            r_p0   <= clamp_r(r_in);
          end
        end
        // p1: full-width sum, accumulator cleared for the multiply
        ADD: begin
          s_p1    <= {1'b0, acc_p0} + {2'b00, blk_p0};
          acc_p2  <= '0;
          cnt_p2  <= '0;
          last_p2 <= 1'b0;
        end
        // p2: one multiplier bit per cycle; the extra cycle after bit 127 publishes the sum
        MUL: begin
          if (!last_p2) begin
            if (r_p0[cnt_p2])
              acc_p2 <= acc_p2 + ({127'b0, s_p1} << cnt_p2);
            cnt_p2 <= cnt_p2 + 7'd1;
            if (cnt_p2 == 7'd127) last_p2 <= 1'b1;
          end else begin
            product   <= acc_p2;
            out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
